// File: rtl/arc_mem_pkg.sv
// Shared types and address decode for the ARC main memory controller.
package arc_mem_pkg;

    localparam logic [31:0] BOOT_WORD_DEF = 32'h81C02800;
    localparam int          USER_BASE_DEF = 2048;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic        hit_sys;
        logic        hit_user;
        logic        misaligned;
        logic [31:0] index;
    } dec_t;

    // Per-transaction response control captured at acceptance.
    typedef struct packed {
        logic we;
        logic err;
        logic sel_sys;
    } rsp_ctl_t;

    function automatic dec_t addr_decode(input logic [63:0] addr,
                                         input logic [63:0] sys_bytes,
                                         input logic [63:0] user_base,
                                         input logic [63:0] user_bytes);
        dec_t        d;
        logic [63:0] off;
        d.misaligned = |addr[1:0];
        d.hit_sys    = addr < sys_bytes;
        d.hit_user   = (addr >= user_base) && (addr < user_base + user_bytes);
        off          = d.hit_user ? addr - user_base : addr;
        d.index      = 32'(off >> 2);
        return d;
    endfunction

endpackage

// File: rtl/arc_mem_bank.sv
// Word array with big-endian per-byte write enables and a registered read port.
module arc_mem_bank #(
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 4,
    parameter logic [DATA_W-1:0] INIT0  = '0,
    parameter int                AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int NB = DATA_W / 8;

    // Power-up image only; reset deliberately leaves the contents alone.
    logic [DATA_W-1:0] mem [DEPTH] = '{0: INIT0, default: '0};

    // be[NB-1] covers the top byte, which is the byte at addr+0.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/arc_main_memory_ctrl.sv
// ARC main memory: system + user banks behind a valid/ready port with fixed read latency.
// Optional ARC_MEM_SYS_WRITE_PROTECT_EN turns system-region writes into error responses.
module arc_main_memory_ctrl
    import arc_mem_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter int                SYS_WORDS  = 4,
    parameter int                USER_BASE  = USER_BASE_DEF,
    parameter int                USER_WORDS = 64,
    parameter int                LATENCY    = 1,
    parameter logic [DATA_W-1:0] BOOT_WORD  = DATA_W'(BOOT_WORD_DEF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W/8-1:0]   req_be,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int SYS_AW  = (SYS_WORDS > 1)  ? $clog2(SYS_WORDS)  : 1;
    localparam int USER_AW = (USER_WORDS > 1) ? $clog2(USER_WORDS) : 1;

    mem_state_e        state;
    logic [3:0]        cnt;
    rsp_ctl_t          ctl_q;
    dec_t              dec;
    logic              accept, err, wp_err;
    logic              sys_we, sys_re, user_we, user_re;
    logic [DATA_W-1:0] sys_rdata, user_rdata;
    logic              unused_idx;

    always_comb dec = addr_decode(64'(req_addr), 64'(4 * SYS_WORDS),
                                  64'(USER_BASE), 64'(4 * USER_WORDS));
    assign unused_idx = ^dec.index;

`ifdef ARC_MEM_SYS_WRITE_PROTECT_EN
    assign wp_err = req_we & dec.hit_sys;
`else
    assign wp_err = 1'b0;
`endif

    assign err       = dec.misaligned | ~(dec.hit_sys | dec.hit_user) | wp_err;
    assign req_ready = rst_n & (state == IDLE);
    assign accept    = req_valid & req_ready;

    assign sys_we  = accept &  req_we & ~err & dec.hit_sys;
    assign sys_re  = accept & ~req_we & ~err & dec.hit_sys;
    assign user_we = accept &  req_we & ~err & dec.hit_user;
    assign user_re = accept & ~req_we & ~err & dec.hit_user;

    arc_mem_bank #(.DATA_W(DATA_W), .DEPTH(SYS_WORDS), .INIT0(BOOT_WORD), .AW(SYS_AW)) u_sys (
        .clk   (clk),
        .we    (sys_we),
        .re    (sys_re),
        .addr  (dec.index[SYS_AW-1:0]),
        .be    (req_be),
        .wdata (req_wdata),
        .rdata (sys_rdata)
    );

    arc_mem_bank #(.DATA_W(DATA_W), .DEPTH(USER_WORDS), .INIT0('0), .AW(USER_AW)) u_user (
        .clk   (clk),
        .we    (user_we),
        .re    (user_re),
        .addr  (dec.index[USER_AW-1:0]),
        .be    (req_be),
        .wdata (req_wdata),
        .rdata (user_rdata)
    );

    // WAIT spans LATENCY-1 cycles so rsp_valid rises LATENCY cycles after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            ctl_q <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    ctl_q <= '{we: req_we, err: err, sel_sys: dec.hit_sys};
                    if (LATENCY == 1) begin
                        state <= RESP;
                    end else begin
                        state <= WAIT;
                        cnt   <= 4'd1;
                    end
                end
                WAIT: if (cnt == 4'(LATENCY - 1)) begin
                    state <= RESP;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bank read registers hold until the next read, so the response stays stable in RESP.
    assign rsp_valid = (state == RESP);
    assign rsp_err   = rsp_valid & ctl_q.err;
    assign rsp_rdata = (rsp_valid & ~ctl_q.we & ~ctl_q.err)
                     ? (ctl_q.sel_sys ? sys_rdata : user_rdata) : '0;

endmodule

// File: tb/tb_arc_main_memory_ctrl.sv
// Directed bench: one controller with LATENCY=1 (d=0) and one with LATENCY=3 (d=1).
module tb_arc_main_memory_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       req_valid = '0, req_we = '0, rsp_ready = '0;
    logic [1:0][31:0] req_addr = '0, req_wdata = '0;
    logic [1:0][3:0]  req_be = '0;
    wire  [1:0]       req_ready, rsp_valid, rsp_err;
    wire  [31:0]      rdata0, rdata1;

    int errors = 0;
    int checks = 0;

    arc_main_memory_ctrl #(.LATENCY(1)) d1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_be(req_be[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rdata0), .rsp_err(rsp_err[0])
    );

    arc_main_memory_ctrl #(.LATENCY(3)) d3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_be(req_be[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rdata1), .rsp_err(rsp_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdata(input int d);
        return (d == 0) ? rdata0 : rdata1;
    endfunction

    // One complete transaction; lat is the cycle count from acceptance to rsp_valid.
    task automatic txn(input int d, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
        req_be[d] = be; req_wdata[d] = wd; rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        lat = 1;
        while (rsp_valid[d] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rdata(d);
        er = rsp_err[d];
        @(posedge clk); #1;
    endtask

    task automatic do_rd(input int d, input logic [31:0] addr, input logic [31:0] exp_d,
                         input logic exp_e, input int exp_lat, input string tag);
        logic [31:0] rd; logic er; int lat;
        txn(d, 1'b0, addr, 4'h0, 32'h0, rd, er, lat);
        chk({tag, "_data"}, rd, exp_d);
        chk({tag, "_err"}, {31'b0, er}, {31'b0, exp_e});
        chk({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic do_wr(input int d, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input logic exp_e, input string tag);
        logic [31:0] rd; logic er; int lat;
        txn(d, 1'b1, addr, be, wd, rd, er, lat);
        chk({tag, "_rdata0"}, rd, 32'h0);
        chk({tag, "_err"}, {31'b0, er}, {31'b0, exp_e});
    endtask

    initial begin
        int lat;
        // reset state
        #12;
        chk("rst_req_ready", {30'b0, req_ready}, 32'h0);
        chk("rst_rsp_valid", {30'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_err", {30'b0, rsp_err}, 32'h0);
        chk("rst_rdata", rdata0, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_req_ready", {30'b0, req_ready}, 32'h3);

        // boot word and sub-word writes
        do_rd(0, 32'd0, 32'h81C02800, 1'b0, 1, "boot");
        do_wr(0, 32'd2092, 4'hF, 32'h00000014, 1'b0, "wr2092");
        do_rd(0, 32'd2092, 32'h00000014, 1'b0, 1, "rd2092");
        do_wr(0, 32'd2092, 4'b0001, 32'hFFFFFFAA, 1'b0, "wr2092_be1");
        do_rd(0, 32'd2092, 32'h000000AA, 1'b0, 1, "rd2092_be1");
        do_wr(0, 32'd2092, 4'b1000, 32'h5BFFFFFF, 1'b0, "wr2092_be8");
        do_rd(0, 32'd2092, 32'h5B0000AA, 1'b0, 1, "rd2092_be8");
        do_wr(0, 32'd2092, 4'b0000, 32'h12345678, 1'b0, "wr2092_be0");
        do_rd(0, 32'd2092, 32'h5B0000AA, 1'b0, 1, "rd2092_be0");

        // errors and region edges
        do_rd(0, 32'd2094, 32'h0, 1'b1, 1, "misalign");
        do_rd(0, 32'd4096, 32'h0, 1'b1, 1, "unmapped");
        do_rd(0, 32'd2304, 32'h0, 1'b1, 1, "user_end");
        do_rd(0, 32'd16, 32'h0, 1'b1, 1, "sys_end");
        do_rd(0, 32'd12, 32'h0, 1'b0, 1, "sys_last");
        do_wr(0, 32'd2300, 4'hF, 32'h000055AA, 1'b0, "wr_last");
        do_wr(0, 32'd4096, 4'hF, 32'hDEADBEEF, 1'b1, "wr_unmapped");
        do_wr(0, 32'd2302, 4'hF, 32'hDEADBEEF, 1'b1, "wr_misalign");
        do_rd(0, 32'd2300, 32'h000055AA, 1'b0, 1, "rd_last");
        do_rd(0, 32'd2048, 32'h0, 1'b0, 1, "rd_first");

        // latency 3 with response back-pressure
        do_wr(1, 32'd2096, 4'hF, 32'h12345678, 1'b0, "l3_wr");
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'd2096; rsp_ready[1] = 1'b0;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        lat = 1;
        while (rsp_valid[1] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("l3_lat", lat, 3);
        chk("l3_data", rdata1, 32'h12345678);
        // a request offered while busy must be ignored
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_be[1] = 4'hF; req_wdata[1] = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'b0, rsp_valid[1]}, 32'h1);
            chk("hold_data", rdata1, 32'h12345678);
            chk("hold_ready", {31'b0, req_ready[1]}, 32'h0);
        end
        @(negedge clk); rsp_ready[1] = 1'b1; req_valid[1] = 1'b0;
        @(posedge clk); #1;
        chk("release_valid", {31'b0, rsp_valid[1]}, 32'h0);
        chk("release_ready", {31'b0, req_ready[1]}, 32'h1);
        do_rd(1, 32'd2096, 32'h12345678, 1'b0, 3, "l3_reread");

        // reset while waiting on a write
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'd2100;
        req_be[1] = 4'hF; req_wdata[1] = 32'h0000001E; rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        chk("wait_no_valid", {31'b0, rsp_valid[1]}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, rsp_valid[1]}, 32'h0);
        chk("midrst_ready", {31'b0, req_ready[1]}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("dropped_rsp", {31'b0, rsp_valid[1]}, 32'h0);
        end
        chk("post_rst_ready", {31'b0, req_ready[1]}, 32'h1);
        do_rd(1, 32'd2100, 32'h0000001E, 1'b0, 3, "rd2100");

        // system-region writes
`ifdef ARC_MEM_SYS_WRITE_PROTECT_EN
        do_wr(0, 32'd0, 4'hF, 32'h12345678, 1'b1, "sys_wr");
        do_rd(0, 32'd0, 32'h81C02800, 1'b0, 1, "sys_rd");
`else
        do_wr(0, 32'd0, 4'hF, 32'h12345678, 1'b0, "sys_wr");
        do_rd(0, 32'd0, 32'h12345678, 1'b0, 1, "sys_rd");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arc_main_memory_ctrl.md
Name: arc_main_memory_ctrl

Overview:
- Parametrised main memory for the ARC softcore, replacing the fixed 32-bit main memory.
- Provides a system region starting at byte 0 and a user region starting at USER_BASE, both with configurable depth.
- Single-port request/response interface with valid/ready handshake, per-byte write enables and configurable read latency.
- Unmapped or misaligned accesses produce an error response. Sits between the CPU control unit and the address/data buses.

Parameters:
- DATA_W, 32: word width; must be a multiple of 8.
- ADDR_W, 32: byte-address width.
- SYS_WORDS, 4: number of words in the system region, byte addresses 0 .. 4*SYS_WORDS-1.
- USER_BASE, 2048: byte address of the first user word; must be word-aligned and greater than 4*SYS_WORDS-1.
- USER_WORDS, 64: number of words in the user region.
- LATENCY, 1: cycles from request acceptance to rsp_valid; must be 1..15.
- BOOT_WORD, 32'h81C02800: value of system word 0 after power-up (jmpl to 2048).

Ports:
- clk, in, 1: system clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: controller can accept a request.
- req_we, in, 1: 1 = write, 0 = read.
- req_addr, in, ADDR_W: byte address.
- req_be, in, DATA_W/8: byte enables. Big-endian: bit MSB selects bits [DATA_W-1 -: 8], i.e. the byte at addr+0.
- req_wdata, in, DATA_W: write data.
- rsp_valid, out, 1: response available.
- rsp_ready, in, 1: consumer takes the response.
- rsp_rdata, out, DATA_W: read data; 0 for writes and for errors.
- rsp_err, out, 1: access was misaligned, unmapped or protected.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to IDLE; req_ready=0 while in reset, 1 in IDLE after release.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
  - Array contents are NOT cleared. System word 0 holds BOOT_WORD only from initial load.
- Acceptance: a request is accepted on a rising edge with req_valid & req_ready. req_ready = (state==IDLE).
- FSM states:
  - IDLE -> WAIT on accept.
  - WAIT: counter counts 1..LATENCY-1 -> RESP; with LATENCY=1, go directly IDLE -> RESP.
  - RESP: hold rsp_valid=1 and rsp_rdata/rsp_err stable until rsp_ready=1. Then -> IDLE, clearing rsp_valid on that edge.
  - One outstanding request at a time; no accept in the RESP->IDLE cycle.
- Decode:
  - Misaligned when req_addr[1:0] != 0.
  - sys hit when addr < 4*SYS_WORDS; user hit when USER_BASE <= addr < USER_BASE + 4*USER_WORDS.
  - Index = (addr - base) >> 2. Anything else is unmapped.
- Writes: commit to the array at the acceptance edge, only the bytes with be=1. be=0 on all lanes is legal and leaves the word unchanged, rsp_err=0.
- Reads: data is sampled at the acceptance edge and registered through the latency stage. A read following a write returns the written data.
- Error (misaligned or unmapped): write suppressed, rsp_rdata=0, rsp_err=1, same latency as a good access.
- Reset mid-operation: a pending response is dropped. A write accepted before reset stays committed.
- req_* inputs are ignored when req_ready=0.

Optional Feature:
- Macro: ARC_MEM_SYS_WRITE_PROTECT_EN.
- Defined: writes that hit the system region are suppressed and return rsp_err=1, rsp_rdata=0. Reads of the system region are unaffected.
- Undefined: system-region writes behave like user-region writes.

Decomposition:
- Package arc_mem_pkg holds:
  - typedef mem_state_e {IDLE, WAIT, RESP};
  - function addr_decode returning {hit_sys, hit_user, misaligned, index};
  - localparam defaults BOOT_WORD_DEF and USER_BASE_DEF.
- One sub-module, arc_mem_bank: synchronous word array with per-byte write enable and a registered read port. Instantiated twice, once for the system region and once for the user region.
- The top level holds decode, FSM and latency counter.

Test Plan:
- After reset, read 0x0 with LATENCY=1 -> rsp_valid one cycle after accept, rsp_rdata=0x81C02800, rsp_err=0.
- Write 0x00000014 to 2092 with be=4'hF, then read 2092 -> 0x00000014. Write be=4'b0001 data 0xFFFFFFAA to the same address, read -> 0x000000AA.
- LATENCY=3: read 2096 -> rsp_valid exactly 3 cycles after accept. Hold rsp_ready=0 for 5 cycles -> data stable, req_ready=0 throughout. Drop to IDLE one cycle after rsp_ready=1.
- Read address 2094 (misaligned) and 4096 (unmapped) -> rsp_err=1, rsp_rdata=0. Write to 4096 followed by a read of the last user word (2048+4*63) -> unchanged.
- Pull rst_n low during WAIT after a write to 2100 of 0x1E -> rsp_valid=0 immediately. After release, read 2100 -> 0x0000001E.
- With ARC_MEM_SYS_WRITE_PROTECT_EN, write 0x0 -> rsp_err=1 and a read of 0x0 still returns 0x81C02800. Without the macro, the same write succeeds.
